// File: rtl/da_shift_acc.sv
// da_shift_acc: bit-plane shift-accumulator for a distributed-arithmetic FIR.
// Takes one signed partial sum per input-sample bit plane (LSB plane first) and
// forms the two's-complement weighted sum. The MSB (sign) plane is subtracted.
// Emits one result per sample with a one-cycle out_valid pulse.
//
// Optional feature: define DA_SHACC_SAT_EN to clip the scaled output y to the
// OUT_W signed range and report it on sat. Without the macro, y wraps and sat
// is tied to 0.
module da_shift_acc #(
  parameter int unsigned IN_W   = 39,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned FRAC   = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  input  logic                     in_first,
  input  logic [IN_W-1:0]          acc_in,
  output logic                     busy,
  output logic                     out_valid,
  output logic [IN_W+DATA_W-1:0]   y_full,
  output logic [OUT_W-1:0]         y,
  output logic                     sat,
  output logic                     seq_err
);

  localparam int unsigned FULL_W = IN_W + DATA_W;
  localparam int unsigned CNT_W  = $clog2(DATA_W) + 1;

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e                   state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic signed [FULL_W-1:0] acc_q;

  logic signed [FULL_W-1:0] in_sext;
  logic signed [FULL_W-1:0] acc_sum;
  logic signed [FULL_W-1:0] acc_final;
  logic                     is_sign_plane;
  logic [OUT_W-1:0]         y_next;
  logic                     sat_next;

  // Datapath: sign-extend the incoming plane sum and form the running and final sums.
  always_comb begin
    in_sext       = {{DATA_W{acc_in[IN_W-1]}}, acc_in};
    acc_sum       = acc_q + (in_sext << cnt_q);
    // The sign plane carries weight -2^(DATA_W-1), hence the subtraction.
    acc_final     = acc_q - (in_sext << (DATA_W - 1));
    is_sign_plane = (cnt_q == CNT_W'(DATA_W - 1));
  end

`ifdef DA_SHACC_SAT_EN
  logic signed [FULL_W-1:0] scaled;
  logic                     in_range;

  // Scale and clip: the result fits OUT_W iff all bits above OUT_W-1 match the sign.
  always_comb begin
    scaled   = acc_final >>> FRAC;
    in_range = (&scaled[FULL_W-1:OUT_W-1]) | ~(|scaled[FULL_W-1:OUT_W-1]);
    y_next   = scaled[OUT_W-1:0];
    sat_next = 1'b0;
    if (!in_range) begin
      sat_next = 1'b1;
      y_next   = scaled[FULL_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  // Scale and wrap: keep only the low OUT_W bits of the shifted result.
  always_comb begin
    y_next   = OUT_W'(acc_final >>> FRAC);
    sat_next = 1'b0;
  end
`endif

  // Control FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      y_full    <= '0;
      y         <= '0;
      sat       <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      seq_err   <= 1'b0;
      if (in_valid) begin
        case (state_q)
          StIdle: begin
            if (in_first) begin
              acc_q   <= in_sext;
              cnt_q   <= CNT_W'(1);
              state_q <= StAccum;
              busy    <= 1'b1;
            end else begin
              // A continuation plane with no sample in progress is dropped.
              seq_err <= 1'b1;
            end
          end
          StAccum: begin
            if (in_first) begin
              // Premature restart: abandon the partial and treat this beat as plane 0.
              seq_err <= 1'b1;
              acc_q   <= in_sext;
              cnt_q   <= CNT_W'(1);
            end else if (is_sign_plane) begin
              y_full    <= acc_final;
              y         <= y_next;
              sat       <= sat_next;
              out_valid <= 1'b1;
              state_q   <= StIdle;
              busy      <= 1'b0;
              cnt_q     <= '0;
              acc_q     <= '0;
            end else begin
              acc_q <= acc_sum;
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_da_shift_acc.sv
// Bench for da_shift_acc: three instances (OUT_W/FRAC = 32/0, 16/0, 32/16) share
// one stimulus stream; a plane-list model predicts every output every cycle.
module tb_da_shift_acc;

  localparam int IN_W   = 39;
  localparam int DATA_W = 16;
  localparam int FULL_W = IN_W + DATA_W;

  logic clk = 1'b0;
  logic resetn, in_valid, in_first;
  logic [IN_W-1:0] acc_in;

  logic busy0, ov0, sat0, se0;
  logic busy1, ov1, sat1, se1;
  logic busy2, ov2, sat2, se2;
  logic [FULL_W-1:0] yf0, yf1, yf2;
  logic [31:0] y0, y2;
  logic [15:0] y1;

  always #5 clk = ~clk;

  da_shift_acc #(.IN_W(IN_W), .DATA_W(DATA_W), .OUT_W(32), .FRAC(0)) dut0 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_first(in_first), .acc_in(acc_in),
    .busy(busy0), .out_valid(ov0), .y_full(yf0), .y(y0), .sat(sat0), .seq_err(se0));
  da_shift_acc #(.IN_W(IN_W), .DATA_W(DATA_W), .OUT_W(16), .FRAC(0)) dut1 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_first(in_first), .acc_in(acc_in),
    .busy(busy1), .out_valid(ov1), .y_full(yf1), .y(y1), .sat(sat1), .seq_err(se1));
  da_shift_acc #(.IN_W(IN_W), .DATA_W(DATA_W), .OUT_W(32), .FRAC(16)) dut2 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_first(in_first), .acc_in(acc_in),
    .busy(busy2), .out_valid(ov2), .y_full(yf2), .y(y2), .sat(sat2), .seq_err(se2));

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  bit chk_en = 0;

  // Model state: planes collected so far for the sample in progress.
  bit     m_active = 0;
  longint planes[$];
  bit     e_busy = 0, e_ov = 0, e_se = 0;
  longint e_yf = 0;
  longint e_y[3] = '{0, 0, 0};
  bit     e_sat[3] = '{0, 0, 0};
  int     outw_t[3] = '{32, 16, 32};
  int     frac_t[3] = '{0, 0, 16};

  longint pl[16];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void calc_y(input longint yf, input int outw, input int frac,
                                 output longint yv, output bit sv);
    longint s, mx, mn;
    s  = yf >>> frac;
    mx = (longint'(1) <<< (outw - 1)) - 1;
    mn = -mx - 1;
    sv = 0;
`ifdef DA_SHACC_SAT_EN
    if (s > mx) begin s = mx; sv = 1; end
    else if (s < mn) begin s = mn; sv = 1; end
`endif
    yv = s & ((longint'(1) << outw) - 1);
  endfunction

  task automatic model_step();
    longint v, sum;
    e_ov = 0;
    e_se = 0;
    if (!resetn) begin
      m_active = 0;
      planes.delete();
      e_busy = 0;
      e_yf = 0;
      for (int i = 0; i < 3; i++) begin e_y[i] = 0; e_sat[i] = 0; end
      return;
    end
    if (in_valid) begin
      v = longint'($signed(acc_in));
      if (in_first) begin
        if (m_active) e_se = 1;
        planes.delete();
        planes.push_back(v);
        m_active = 1;
      end else if (!m_active) begin
        e_se = 1;
      end else begin
        planes.push_back(v);
        if (planes.size() == DATA_W) begin
          sum = 0;
          for (int k = 0; k < DATA_W - 1; k++) sum += planes[k] * (longint'(1) << k);
          sum -= planes[DATA_W-1] * (longint'(1) << (DATA_W - 1));
          e_yf = sum;
          for (int i = 0; i < 3; i++) calc_y(sum, outw_t[i], frac_t[i], e_y[i], e_sat[i]);
          e_ov = 1;
          m_active = 0;
          planes.delete();
          n_done++;
        end
      end
    end
    e_busy = m_active;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison of all three instances against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("busy0", busy0, e_busy);  check("busy1", busy1, e_busy);  check("busy2", busy2, e_busy);
      check("ov0", ov0, e_ov);        check("ov1", ov1, e_ov);        check("ov2", ov2, e_ov);
      check("seq_err0", se0, e_se);   check("seq_err1", se1, e_se);   check("seq_err2", se2, e_se);
      check("y_full0", longint'($signed(yf0)), e_yf);
      check("y_full1", longint'($signed(yf1)), e_yf);
      check("y_full2", longint'($signed(yf2)), e_yf);
      check("y0", longint'(y0), e_y[0]); check("y1", longint'(y1), e_y[1]);
      check("y2", longint'(y2), e_y[2]);
      check("sat0", sat0, e_sat[0]); check("sat1", sat1, e_sat[1]); check("sat2", sat2, e_sat[2]);
    end
  end

  task automatic beat(input bit f, input longint v);
    in_valid = 1;
    in_first = f;
    acc_in   = v[IN_W-1:0];
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    in_first = 0;
    repeat (n) @(negedge clk);
  endtask

  // Send pl[0..15]; optional idle gap between planes 7 and 8.
  task automatic sample(input int gap);
    for (int k = 0; k < DATA_W; k++) begin
      if (k == 8 && gap > 0) idle(gap);
      beat(k == 0, pl[k]);
    end
  endtask

  task automatic set_pl(input longint fill);
    for (int k = 0; k < DATA_W; k++) pl[k] = fill;
  endtask

  function automatic longint rval();
    logic [63:0] t;
    longint x;
    case ($urandom_range(0, 3))
      0: begin t = {$urandom, $urandom}; x = longint'($signed(t[IN_W-1:0])); end
      1: x = longint'($urandom_range(0, 20)) - 10;
      2: x = (longint'(1) << (IN_W - 1)) - 1;
      default: x = -(longint'(1) << (IN_W - 1));
    endcase
    return x;
  endfunction

  initial begin
    resetn = 0; in_valid = 0; in_first = 0; acc_in = '0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    check("reset_busy", busy0, 0);
    check("reset_yfull", longint'(yf0), 0);
    resetn = 1;
    idle(2);

    // 1: all planes 1 -> -1
    set_pl(1);
    sample(0);
    check("t1_ov", ov0, 1);
    check("t1_yfull", longint'($signed(yf0)), -1);
    check("t1_y", longint'(y0), 64'h0000_0000_FFFF_FFFF);
    check("t1_model", e_yf, -1);
    idle(1);
    check("t1_ov_pulse", ov0, 0);

    // 2: plane0=5, then back-to-back plane15=3
    set_pl(0); pl[0] = 5;
    sample(0);
    check("t2a_yfull", longint'($signed(yf0)), 5);
    set_pl(0); pl[15] = 3;
    sample(0);
    check("t2b_yfull", longint'($signed(yf0)), -98304);
    check("t2b_model", e_yf, -98304);
    idle(2);

    // 3: gap of 3 between planes 7 and 8
    set_pl(1);
    sample(3);
    check("t3_ov", ov0, 1);
    check("t3_yfull", longint'($signed(yf0)), -1);
    idle(2);

    // 4: premature restart, then a clean sample
    set_pl(1);
    for (int k = 0; k < 9; k++) beat(k == 0, pl[k]);
    beat(1, 7);
    check("t4_seq_err", se0, 1);
    set_pl(0); pl[0] = 2;
    sample(0);
    check("t4_yfull", longint'($signed(yf0)), 2);
    idle(2);

    // 5: reset mid-sample, then the plane0=5 sample
    set_pl(1);
    for (int k = 0; k < 7; k++) beat(k == 0, pl[k]);
    in_valid = 0; resetn = 0;
    @(negedge clk);
    check("t5_busy_reset", busy0, 0);
    resetn = 1;
    set_pl(0); pl[0] = 5;
    sample(0);
    check("t5_yfull", longint'($signed(yf0)), 5);
    idle(2);

    // 6: plane14=2 -> 32768 into the 16-bit instance
    set_pl(0); pl[14] = 2;
    sample(0);
    check("t6_yfull", longint'($signed(yf1)), 32768);
`ifdef DA_SHACC_SAT_EN
    check("t6_y16", longint'(y1), 64'h7FFF);
    check("t6_sat16", sat1, 1);
    check("t6_model", e_y[1], 64'h7FFF);
`else
    check("t6_y16", longint'(y1), 64'h8000);
    check("t6_sat16", sat1, 0);
    check("t6_model", e_y[1], 64'h8000);
`endif
    check("t6_y32", longint'(y0), 32768);
    idle(2);

    // Randomized stream with gaps, restarts, stray planes and occasional reset.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        in_valid = 0; resetn = 0;
        @(negedge clk);
        resetn = 1;
      end else begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_first = m_active ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) != 0);
        acc_in   = IN_W'(rval());
        @(negedge clk);
      end
    end
    idle(3);
    check("rand_results_seen", longint'(n_done > 20), 1);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
